// File: rtl/vector_pkg.sv
// Shared op codes and sequencer state encoding for the vector ALU sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vector_pkg;

  // Mirrors the vector_element_alu op_sel encoding; 3'd7 has no ALU function.
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_MIN  = 3'd5,
    OP_MAX  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_SET     = 2'd2,
    ST_CAPTURE = 2'd3
  } state_e;

endpackage

// File: rtl/vector_reg_bank.sv
// REGS x N x BITS vector register file: one full-vector write, one element write,
// two vector reads and one element read. Reads are combinational; writes land on
// the next clock edge. No backpressure; async active-low reset clears every element.
// Ports: vec_* full-vector write, el_* element write, rd_a/rd_b vector reads,
//        rd_e element read.
module vector_reg_bank #(
  parameter  int BITS = 8,
  parameter  int N    = 4,
  parameter  int REGS = 4,
  localparam int RW   = $clog2(REGS),
  localparam int EW   = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vec_we,
  input  logic [RW-1:0]           vec_idx,
  input  logic [N-1:0][BITS-1:0]  vec_wdata,
  input  logic                    el_we,
  input  logic [RW-1:0]           el_reg,
  input  logic [EW-1:0]           el_idx,
  input  logic [BITS-1:0]         el_wdata,
  input  logic [RW-1:0]           rd_a_idx,
  output logic [N-1:0][BITS-1:0]  rd_a_dat,
  input  logic [RW-1:0]           rd_b_idx,
  output logic [N-1:0][BITS-1:0]  rd_b_dat,
  input  logic [RW-1:0]           rd_e_reg,
  input  logic [EW-1:0]           rd_e_idx,
  output logic [BITS-1:0]         rd_e_dat
);

  logic [REGS-1:0][N-1:0][BITS-1:0] mem_q, mem_d;

  // The sequencer never raises both write ports in the same cycle (element
  // writes only in IDLE, vector writes only in CAPTURE); vector wins if it did.
  always_comb begin
    mem_d = mem_q;
    if (el_we) begin
      mem_d[el_reg][el_idx] = el_wdata;
    end
    if (vec_we) begin
      mem_d[vec_idx] = vec_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_a_dat = mem_q[rd_a_idx];
  assign rd_b_dat = mem_q[rd_b_idx];
  assign rd_e_dat = mem_q[rd_e_reg][rd_e_idx];

endmodule

// File: rtl/vector_alu_sequencer.sv
// Command sequencer for vector_element_alu: reads two source vectors, strobes the ALU, writes S back.
// Latency: accept -> done is 3 cycles (LOAD, SET, CAPTURE); one op per 4 cycles peak.
// Backpressure: cmd_ready is low while an op is in flight; host writes while busy are dropped and flag err.
// Ports: cmd_* valid/ready command; done/err/busy status; host_* element load and
//        readback; alu_* operand/control outputs and alu_s result input.
module vector_alu_sequencer
  import vector_pkg::*;
#(
  parameter  int BITS = 8,
  parameter  int N    = 4,
  parameter  int REGS = 4,
  localparam int RW   = $clog2(REGS),
  localparam int EW   = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_op,
  input  logic                    cmd_scalar_sel,
  input  logic [BITS-1:0]         cmd_scalar,
  input  logic [RW-1:0]           cmd_src_a,
  input  logic [RW-1:0]           cmd_src_b,
  input  logic [RW-1:0]           cmd_dst,
  output logic                    done,
  output logic                    err,
  output logic                    busy,
  input  logic                    host_we,
  input  logic [RW-1:0]           host_reg,
  input  logic [EW-1:0]           host_elem,
  input  logic [BITS-1:0]         host_wdata,
  output logic [BITS-1:0]         host_rdata,
  output logic [N-1:0][BITS-1:0]  alu_a,
  output logic [N-1:0][BITS-1:0]  alu_b,
  output logic [BITS-1:0]         alu_scalar,
  output logic [2:0]              alu_op_sel,
  output logic                    alu_scalar_sel,
  output logic                    alu_en,
  output logic                    alu_set,
  input  logic [N-1:0][BITS-1:0]  alu_s
);

  state_e                  state_q, state_d;
  logic [2:0]              op_q, op_d;
  logic                    scalar_sel_q, scalar_sel_d;
  logic [BITS-1:0]         scalar_q, scalar_d;
  logic [RW-1:0]           src_a_q, src_a_d;
  logic [RW-1:0]           src_b_q, src_b_d;
  logic [RW-1:0]           dst_q, dst_d;
  logic [N-1:0][BITS-1:0]  alu_a_q, alu_a_d;
  logic [N-1:0][BITS-1:0]  alu_b_q, alu_b_d;
  logic                    err_q, err_d;

  logic                    accept;
  logic                    host_wr_ok;
  logic [N-1:0][BITS-1:0]  rd_a_dat, rd_b_dat;

  // Gate with rst_n so the host never sees ready while reset is held.
  assign busy       = (state_q != ST_IDLE);
  assign cmd_ready  = rst_n && !busy;
  assign accept     = cmd_valid && cmd_ready;
  assign host_wr_ok = host_we && !busy;

  // Source indices come from the latched command, so an element write that
  // lands on the accept edge is already visible when LOAD reads the bank.
  vector_reg_bank #(.BITS(BITS), .N(N), .REGS(REGS)) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .vec_we    (state_q == ST_CAPTURE),
    .vec_idx   (dst_q),
    .vec_wdata (alu_s),
    .el_we     (host_wr_ok),
    .el_reg    (host_reg),
    .el_idx    (host_elem),
    .el_wdata  (host_wdata),
    .rd_a_idx  (src_a_q),
    .rd_a_dat  (rd_a_dat),
    .rd_b_idx  (src_b_q),
    .rd_b_dat  (rd_b_dat),
    .rd_e_reg  (host_reg),
    .rd_e_idx  (host_elem),
    .rd_e_dat  (host_rdata)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    scalar_sel_d = scalar_sel_q;
    scalar_d     = scalar_q;
    src_a_d      = src_a_q;
    src_b_d      = src_b_q;
    dst_d        = dst_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    err_d        = host_we && busy;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_op == OP_RSVD) begin
            err_d = 1'b1;
          end else begin
            op_d         = cmd_op;
            scalar_sel_d = cmd_scalar_sel;
            scalar_d     = cmd_scalar;
            src_a_d      = cmd_src_a;
            src_b_d      = cmd_src_b;
            dst_d        = cmd_dst;
            state_d      = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        // Snapshot operands so they hold through SET/CAPTURE and afterwards,
        // even when dst aliases a source and the bank changes on CAPTURE.
        alu_a_d = rd_a_dat;
        alu_b_d = rd_b_dat;
        state_d = ST_SET;
      end
      ST_SET:     state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      scalar_sel_q <= 1'b0;
      scalar_q     <= '0;
      src_a_q      <= '0;
      src_b_q      <= '0;
      dst_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      scalar_sel_q <= scalar_sel_d;
      scalar_q     <= scalar_d;
      src_a_q      <= src_a_d;
      src_b_q      <= src_b_d;
      dst_q        <= dst_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      err_q        <= err_d;
    end
  end

  assign alu_a          = (state_q == ST_LOAD) ? rd_a_dat : alu_a_q;
  assign alu_b          = (state_q == ST_LOAD) ? rd_b_dat : alu_b_q;
  assign alu_scalar     = scalar_q;
  assign alu_op_sel     = op_q;
  assign alu_scalar_sel = scalar_sel_q;
  assign alu_en         = busy;
  assign alu_set        = (state_q == ST_SET);
  assign done           = (state_q == ST_CAPTURE);
  assign err            = err_q;

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Self-checking bench for vector_alu_sequencer: timeline/bank reference model,
// per-cycle output compare, a stand-in ALU, directed and randomized stimulus.
module tb_vector_alu_sequencer;

  localparam int BITS = 8;
  localparam int N    = 4;
  localparam int REGS = 4;
  localparam int RW   = 2;
  localparam int EW   = 2;

  logic                   clk, rst_n;
  logic                   cmd_valid, cmd_ready;
  logic [2:0]             cmd_op;
  logic                   cmd_scalar_sel;
  logic [BITS-1:0]        cmd_scalar;
  logic [RW-1:0]          cmd_src_a, cmd_src_b, cmd_dst;
  logic                   done, err, busy;
  logic                   host_we;
  logic [RW-1:0]          host_reg;
  logic [EW-1:0]          host_elem;
  logic [BITS-1:0]        host_wdata, host_rdata;
  logic [N-1:0][BITS-1:0] alu_a, alu_b, alu_s;
  logic [BITS-1:0]        alu_scalar;
  logic [2:0]             alu_op_sel;
  logic                   alu_scalar_sel, alu_en, alu_set;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0, set_cnt = 0, err_cnt = 0, last_done = -1;

  vector_alu_sequencer #(.BITS(BITS), .N(N), .REGS(REGS)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_scalar_sel(cmd_scalar_sel), .cmd_scalar(cmd_scalar),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
    .done(done), .err(err), .busy(busy),
    .host_we(host_we), .host_reg(host_reg), .host_elem(host_elem),
    .host_wdata(host_wdata), .host_rdata(host_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_scalar(alu_scalar), .alu_op_sel(alu_op_sel),
    .alu_scalar_sel(alu_scalar_sel), .alu_en(alu_en), .alu_set(alu_set), .alu_s(alu_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [BITS-1:0] alu_f(input logic [2:0] op, input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (a < b) ? a : b;
      3'd6: return (a > b) ? a : b;
      default: return '0;
    endcase
  endfunction

  // Stand-in ALU: result registered on alu_set with alu_en, valid next cycle.
  always @(posedge clk) begin
    if (alu_set && alu_en) begin
      for (int i = 0; i < N; i++)
        alu_s[i] <= alu_f(alu_op_sel, alu_a[i], alu_scalar_sel ? alu_scalar : alu_b[i]);
    end
  end

  // Reference model: bank contents plus the age of the op in flight
  // (0 = none, 1..3 = cycles since accept).
  logic [BITS-1:0] mb [REGS][N];
  logic [BITS-1:0] ma [N];
  logic [BITS-1:0] mbv [N];
  logic [BITS-1:0] mres [N];
  logic [2:0]      mop;
  logic            mss;
  logic [BITS-1:0] msc;
  logic [RW-1:0]   mdst;
  logic            merr;
  int              age;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REGS; r++)
        for (int e = 0; e < N; e++) mb[r][e] = '0;
      for (int e = 0; e < N; e++) begin ma[e] = '0; mbv[e] = '0; mres[e] = '0; end
      mop = '0; mss = 1'b0; msc = '0; mdst = '0; merr = 1'b0; age = 0;
    end else begin
      logic acc;
      acc  = cmd_valid && (age == 0);
      merr = (acc && cmd_op == 3'd7) || (host_we && age != 0);
      if (host_we && age == 0) mb[host_reg][host_elem] = host_wdata;
      if (age == 3) begin
        for (int e = 0; e < N; e++) mb[mdst][e] = mres[e];
        age = 0;
      end else if (age != 0) begin
        age = age + 1;
      end else if (acc && cmd_op != 3'd7) begin
        mop = cmd_op; mss = cmd_scalar_sel; msc = cmd_scalar; mdst = cmd_dst;
        for (int e = 0; e < N; e++) begin
          ma[e]   = mb[cmd_src_a][e];
          mbv[e]  = mb[cmd_src_b][e];
          mres[e] = alu_f(cmd_op, ma[e], cmd_scalar_sel ? cmd_scalar : mbv[e]);
        end
        age = 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    chk("cmd_ready", cmd_ready, rst_n && age == 0);
    chk("busy", busy, age != 0);
    chk("alu_en", alu_en, age != 0);
    chk("alu_set", alu_set, age == 2);
    chk("done", done, age == 3);
    chk("err", err, merr);
    chk("alu_op_sel", alu_op_sel, mop);
    chk("alu_scalar_sel", alu_scalar_sel, mss);
    chk("alu_scalar", alu_scalar, msc);
    for (int e = 0; e < N; e++) begin
      chk("alu_a", alu_a[e], ma[e]);
      chk("alu_b", alu_b[e], mbv[e]);
    end
    chk("host_rdata", host_rdata, mb[host_reg][host_elem]);
  end

  always @(negedge clk) begin
    if (done) begin done_cnt++; last_done = cyc; end
    if (alu_set) set_cnt++;
    if (err) err_cnt++;
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin tick(); n++; end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic host_wr(input int r, input int e, input logic [BITS-1:0] d);
    host_we = 1'b1; host_reg = RW'(r); host_elem = EW'(e); host_wdata = d;
    tick();
    host_we = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic ss, input logic [BITS-1:0] sc,
                       input int a, input int b, input int d, output int acc);
    int n = 0;
    cmd_op = op; cmd_scalar_sel = ss; cmd_scalar = sc;
    cmd_src_a = RW'(a); cmd_src_b = RW'(b); cmd_dst = RW'(d);
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    chk("accept_timeout", n < 20, 1'b1);
    acc = cyc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic rd(input int r, input int e, output logic [BITS-1:0] v);
    host_reg = RW'(r); host_elem = EW'(e);
    #1;
    v = host_rdata;
  endtask

  initial begin
    int a1, a2, a3, s0, d0, e0;
    logic [BITS-1:0] v;
    logic [BITS-1:0] init_r0 [N];
    logic [BITS-1:0] r0_snap [N];
    init_r0 = '{8'd20, 8'd10, 8'd5, 8'd0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_scalar_sel = 1'b0; cmd_scalar = '0;
    cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0;
    host_we = 1'b0; host_reg = '0; host_elem = '0; host_wdata = '0;
    #1;
    chk("ready_in_reset", cmd_ready, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("ready_after_rst", cmd_ready, 1'b1);
    tick();

    // Basic op: r1 = r0 + 0xFF (scalar)
    for (int e = 0; e < N; e++) host_wr(0, e, init_r0[e]);
    s0 = set_cnt;
    issue(3'd0, 1'b1, 8'hFF, 0, 0, 1, a1);
    wait_idle();
    chk("basic_latency", last_done - a1, 3);
    chk("basic_set_once", set_cnt - s0, 1);
    rd(1, 0, v); chk("basic_r1_0", v, 8'd19);
    rd(1, 1, v); chk("basic_r1_1", v, 8'd9);
    rd(1, 2, v); chk("basic_r1_2", v, 8'd4);
    rd(1, 3, v); chk("basic_r1_3", v, 8'd255);

    // Back-to-back
    d0 = done_cnt;
    issue(3'd1, 1'b0, 8'h00, 0, 1, 2, a1);   // r2 = r0 - r1
    issue(3'd4, 1'b0, 8'h00, 1, 2, 3, a2);   // r3 = r1 ^ r2
    issue(3'd6, 1'b0, 8'h00, 0, 3, 0, a3);   // r0 = max(r0, r3)
    wait_idle();
    chk("b2b_spacing_1", a2 - a1, 4);
    chk("b2b_spacing_2", a3 - a2, 4);
    chk("b2b_done_cnt", done_cnt - d0, 3);
    rd(2, 3, v); chk("b2b_r2_3", v, 8'd1);
    rd(3, 0, v); chk("b2b_r3_0", v, 8'd18);
    rd(3, 3, v); chk("b2b_r3_3", v, 8'd254);
    rd(0, 3, v); chk("b2b_r0_3", v, 8'd254);

    // Aliasing: r2 = r2 + r2 (r2 was all ones)
    s0 = set_cnt;
    issue(3'd0, 1'b0, 8'h00, 2, 2, 2, a1);
    wait_idle();
    rd(2, 0, v); chk("alias_r2_0", v, 8'd2);
    rd(2, 2, v); chk("alias_r2_2", v, 8'd2);
    chk("alias_set_once", set_cnt - s0, 1);

    // Reserved op
    for (int e = 0; e < N; e++) begin rd(0, e, v); r0_snap[e] = v; end
    e0 = err_cnt; s0 = set_cnt;
    issue(3'd7, 1'b0, 8'h00, 1, 1, 0, a1);
    tick(); tick();
    chk("rsvd_err_pulse", err_cnt - e0, 1);
    chk("rsvd_no_set", set_cnt - s0, 0);
    for (int e = 0; e < N; e++) begin rd(0, e, v); chk("rsvd_bank", v, r0_snap[e]); end

    // Host write while busy is dropped
    e0 = err_cnt;
    issue(3'd3, 1'b0, 8'h00, 0, 1, 3, a1);
    host_wr(1, 0, 8'hAA);
    wait_idle();
    chk("conflict_err", err_cnt - e0, 1);
    rd(1, 0, v); chk("conflict_r1_0", v, 8'd19);

    // Host write + accept in the same IDLE cycle
    host_we = 1'b1; host_reg = 2'd0; host_elem = 2'd0; host_wdata = 8'h40;
    cmd_op = 3'd0; cmd_scalar_sel = 1'b1; cmd_scalar = 8'h01;
    cmd_src_a = 2'd0; cmd_src_b = 2'd0; cmd_dst = 2'd3; cmd_valid = 1'b1;
    chk("same_cycle_ready", cmd_ready, 1'b1);
    tick();
    host_we = 1'b0; cmd_valid = 1'b0;
    wait_idle();
    rd(3, 0, v); chk("same_cycle_r3_0", v, 8'h41);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      host_reg   = RW'($urandom_range(0, REGS - 1));
      host_elem  = EW'($urandom_range(0, N - 1));
      host_wdata = BITS'($urandom);
      host_we    = ($urandom_range(0, 3) == 0);
      cmd_valid  = ($urandom_range(0, 1) == 1);
      cmd_op     = 3'($urandom_range(0, 7));
      cmd_scalar_sel = 1'($urandom);
      cmd_scalar = BITS'($urandom);
      cmd_src_a  = RW'($urandom); cmd_src_b = RW'($urandom); cmd_dst = RW'($urandom);
      tick();
    end
    host_we = 1'b0; cmd_valid = 1'b0;
    wait_idle();

    // Reset asserted mid-LOAD
    issue(3'd2, 1'b0, 8'h00, 0, 1, 2, a1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_alu_en", alu_en, 1'b0);
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_alu_a", alu_a, '0);
    chk("rst_alu_op", alu_op_sel, 3'd0);
    for (int r = 0; r < REGS; r++)
      for (int e = 0; e < N; e++) begin rd(r, e, v); chk("rst_bank", v, 8'd0); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("ready_after_rst2", cmd_ready, 1'b1);
    tick();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
